// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter steering a shared 4:1 mux: registered one-hot grant, select and valid.
// Optional hold-limit rotation is built when ARB_TIMEOUT_EN is defined.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CW) <= MAX_HOLD) begin : g_cfg_error
    $error("mux4_rr_arbiter: MAX_HOLD must be 2..255 and fit in CW bits");
  end

  logic [0:0] state;
  logic [1:0] last;
`ifdef ARB_TIMEOUT_EN
  logic [CW-1:0] cnt;
`endif

  // First set request in the order base+1, base+2, base+3, base.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    logic       found;
    pick  = base;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  logic [1:0] win_idle;
  logic [1:0] win_next;
  logic       owner_req;
  logic       others;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    win_idle  = pick(req, last);
    // Masking the owner lets a forced rotation skip it; on release req[owner] is already 0.
    win_next  = pick(req & ~gnt, sel);
    owner_req = |(req & gnt);
    others    = |(req & ~gnt);
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'b00;
      valid <= 1'b0;
      last  <= 2'b11;
`ifdef ARB_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state <= GRANT;
            gnt   <= 4'b0001 << win_idle;
            sel   <= win_idle;
            valid <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        end
        default: begin
          if (!owner_req) begin
            last <= sel;
            if (others) begin
              gnt <= 4'b0001 << win_next;
              sel <= win_next;
`ifdef ARB_TIMEOUT_EN
              cnt <= '0;
`endif
            end else begin
              // sel keeps the old owner so the mux output stays stable while idle.
              state <= IDLE;
              gnt   <= 4'b0000;
              valid <= 1'b0;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt == CW'(MAX_HOLD - 1)) begin
            cnt <= '0;
            if (others) begin
              last <= sel;
              gnt  <= 4'b0001 << win_next;
              sel  <= win_next;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, hold, rotation, release-to-idle, mid-grant reset,
// and the hold-limit rotation when ARB_TIMEOUT_EN is defined.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;

  int errors = 0;
  int checks = 0;

`ifdef ARB_TIMEOUT_EN
  mux4_rr_arbiter #(.MAX_HOLD(4), .CW(8)) dut (
`else
  mux4_rr_arbiter dut (
`endif
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are changed and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic v);
    check({tag, ".gnt"}, gnt, g);
    check({tag, ".sel"}, {2'b00, sel}, {2'b00, s});
    check({tag, ".valid"}, {3'b000, valid}, {3'b000, v});
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    step();
    step();
    rst = 1'b0;
    check_out("reset", 4'b0000, 2'd0, 1'b0);

    // Single requester: granted one cycle later, then held while req stays high.
    req = 4'b0001;
    step();
    check_out("first_grant", 4'b0001, 2'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step();
      check("hold_0", gnt, 4'b0001);
    end

    // Fresh reset, all request; each owner drops for one cycle -> 0,1,2,3,0 without a gap.
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
    req = 4'b1111;
    step();
    check_out("rot_0", 4'b0001, 2'd0, 1'b1);
    req = 4'b1110;
    step();
    check_out("rot_1", 4'b0010, 2'd1, 1'b1);
    req = 4'b1101;
    step();
    check_out("rot_2", 4'b0100, 2'd2, 1'b1);
    req = 4'b1011;
    step();
    check_out("rot_3", 4'b1000, 2'd3, 1'b1);
    req = 4'b0111;
    step();
    check_out("rot_wrap", 4'b0001, 2'd0, 1'b1);

    // Hand over to 1, then 1 releases with 3 and 0 pending: 3 comes first.
    req = 4'b0010;
    step();
    check_out("to_1", 4'b0010, 2'd1, 1'b1);
    req = 4'b1001;
    step();
    check_out("skip_to_3", 4'b1000, 2'd3, 1'b1);

    // Hand over to 2, then everyone drops: idle with sel held at 2.
    req = 4'b0100;
    step();
    check_out("to_2", 4'b0100, 2'd2, 1'b1);
    req = 4'b0000;
    step();
    check_out("idle", 4'b0000, 2'd2, 1'b0);
    step();
    check_out("idle_hold", 4'b0000, 2'd2, 1'b0);
    req = 4'b0100;
    step();
    check_out("regrant_2", 4'b0100, 2'd2, 1'b1);

    // Grant 3 under full request, then a one-cycle reset.
    req = 4'b1000;
    step();
    check_out("to_3", 4'b1000, 2'd3, 1'b1);
    req = 4'b1111;
    step();
    check_out("hold_3", 4'b1000, 2'd3, 1'b1);
    rst = 1'b1;
    step();
    check_out("mid_reset", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    step();
    check_out("after_reset", 4'b0001, 2'd0, 1'b1);

`ifdef ARB_TIMEOUT_EN
    // MAX_HOLD=4: two contenders alternate every 4 cycles; a lone owner keeps the grant.
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
    req = 4'b0011;
    step();
    check("to_hold_a", gnt, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_hold_a", gnt, 4'b0001);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      check("to_hold_b", gnt, 4'b0010);
    end
    step();
    check("to_back_a", gnt, 4'b0001);
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step();
      check("to_alone", gnt, 4'b0001);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux datapath among four requesters.
- Drives the mux's 2-bit select plus a one-hot grant back to the requesters.
- A grant is held until the owner releases its request, or optionally until a hold limit expires.
- Sits beside the 4:1 mux. Requester i's data is wired to mux input i, and `sel` goes straight to the mux select.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles per owner when ARB_TIMEOUT_EN is defined. Legal range is 2..255; ignored otherwise.
- CW, 8, width of the hold counter. Must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request lines; req[i] from requester i.
- gnt  output 4  registered one-hot grant; all zero when idle.
- sel  output 2  registered mux select, equal to the binary index of the current owner.
- valid  output 1  registered; high when any gnt bit is high.

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - state=IDLE, gnt=4'b0000, sel=2'b00, valid=0.
  - last=2'b11, so requester 0 has first priority after reset.
  - Hold counter cnt=0.
- Priority order: search starts at last+1 and wraps modulo 4, i.e. last+1, last+2, last+3, last. The first set req bit in that order wins.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE with gnt=0.
  - Otherwise the winner w is registered on the next edge: gnt=1<<w, sel=w, valid=1, cnt=0, state=GRANT.
  - Latency: req asserted in cycle n gives gnt in cycle n+1.
- GRANT, owner o:
  - Hold: while req[o]==1 and no timeout, gnt, sel and valid are unchanged; cnt increments.
  - Release: req[o]==0 sets last=o.
    - If other requests are pending, the next owner per the rotation (starting at o+1) is granted on the same edge. There is no idle bubble; gnt changes directly from one one-hot value to another.
    - If no requests are pending, the next edge gives gnt=0, valid=0, state=IDLE. sel keeps o.
  - Deassertion of req is observed with 1-cycle latency. The old owner still sees gnt for the cycle in which it dropped req.
- gnt is always one-hot or zero and is never multi-hot. sel always equals the index of the set gnt bit.
- sel holds its last value in IDLE, so the mux output stays stable.
- Simultaneous events:
  - The owner releasing while new requests arrive in the same cycle is resolved by one rotation using that cycle's req.
  - A request arriving from a requester that is already granted has no effect.
- Reset mid-grant: on the next edge all state returns to reset values regardless of req. Arbitration resumes one cycle after rst falls.
- Requests are not latched. A req pulse that drops before it wins is lost.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, cnt counts owner cycles starting from 0.
  - When cnt==MAX_HOLD-1 with req[o] still high and any other req bit set, the next edge sets last=o and grants the next requester in rotation; cnt restarts at 0.
  - If no other requester is pending at the limit, the owner keeps the grant and cnt restarts at 0.
  - A forced rotation follows the same no-bubble rules as a release.
- Undefined: no counter is synthesised; the owner keeps the grant indefinitely while req[o]==1. MAX_HOLD and CW are unused.

Test Plan:
- Reset, then req=4'b0001 at cycle 1 -> gnt=4'b0001, sel=0, valid=1 at cycle 2. With req held, the grant is stable for 20 cycles (macro off).
- req=4'b1111 held, each owner drops req for one cycle after taking the grant, then reasserts -> grant order 0,1,2,3,0 with no cycle of gnt=0 between owners.
- last=1, owner 1 releases while req=4'b1001 -> next gnt=4'b1000 (3 precedes 0 in rotation), sel=3.
- Owner 2 drops req and req=0 -> next cycle gnt=0, valid=0, sel stays 2. A later req=4'b0100 is granted one cycle after assertion.
- rst asserted for 1 cycle during a grant to 3 with req=4'b1111 -> next edge gnt=0, sel=0, valid=0. First grant after reset goes to 0.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011 held -> gnt alternates 0001 and 0010 every 4 cycles. With req=4'b0001 only, gnt stays 0001 past 4 cycles.
